// File: rtl/nmi_slave_demux.sv
// Registered 1-to-N demultiplexer on the native memory interface.
// Steers each master transaction to one decoded slave; misses and timeouts get ERR_RDATA.
module nmi_slave_demux #(
   parameter int unsigned               SLV_NUM     = 4,
   parameter logic [SLV_NUM*32-1:0]     SLV_BASE    = {32'h4000_0000, 32'h3000_0000,
                                                       32'h1000_0000, 32'h0000_0000},
   parameter logic [SLV_NUM*32-1:0]     SLV_MASK    = {4{32'hF000_0000}},
   parameter int unsigned               TIMEOUT_CYC = 255,
   parameter logic [31:0]               ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  m_valid_i,
   input  logic [31:0]           m_addr_i,
   input  logic [31:0]           m_wdata_i,
   input  logic [3:0]            m_wstrb_i,
   output logic                  m_ready_o,
   output logic [31:0]           m_rdata_o,
   output logic [SLV_NUM-1:0]    s_valid_o,
   output logic [31:0]           s_addr_o,
   output logic [31:0]           s_wdata_o,
   output logic [3:0]            s_wstrb_o,
   input  logic [SLV_NUM-1:0]    s_ready_i,
   input  logic [SLV_NUM*32-1:0] s_rdata_i,
   input  logic                  err_clr_i,
   output logic                  err_o,
   output logic [31:0]           err_addr_o
);

   localparam int SEL_W = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_ERR
   } state_e;

   state_e             state_q,    state_d;
   logic [CNT_W-1:0]   cnt_q,      cnt_d;
   logic [SEL_W-1:0]   sel_q,      sel_d;
   logic [SLV_NUM-1:0] s_valid_q,  s_valid_d;
   logic [31:0]        s_addr_q,   s_addr_d;
   logic [31:0]        s_wdata_q,  s_wdata_d;
   logic [3:0]         s_wstrb_q,  s_wstrb_d;
   logic               m_ready_q,  m_ready_d;
   logic [31:0]        m_rdata_q,  m_rdata_d;
   logic               err_q,      err_d;
   logic [31:0]        err_addr_q, err_addr_d;

   logic               hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               sel_ready;
   logic [31:0]        sel_rdata;

   // Scanning from the top down lets the lowest-indexed hitting slave win.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = int'(SLV_NUM) - 1; i >= 0; i--) begin
         if ((m_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < int'(SLV_NUM); i++) begin
         if (sel_q == SEL_W'(i)) begin
            sel_ready = s_ready_i[i];
            sel_rdata = s_rdata_i[i*32 +: 32];
         end
      end
   end

   // NOTE: every _d gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel_q;
      s_valid_d  = '0;
      s_addr_d   = s_addr_q;
      s_wdata_d  = s_wdata_q;
      s_wstrb_d  = s_wstrb_q;
      m_ready_d  = 1'b0;
      m_rdata_d  = m_rdata_q;
      err_d      = err_q & ~err_clr_i;
      err_addr_d = err_addr_q;

      unique case (state_q)
         ST_IDLE: begin
            if (m_valid_i) begin
               if (hit) begin
                  state_d            = ST_REQ;
                  sel_d              = hit_idx;
                  cnt_d              = '0;
                  s_addr_d           = m_addr_i;
                  s_wdata_d          = m_wdata_i;
                  s_wstrb_d          = m_wstrb_i;
                  s_valid_d[hit_idx] = 1'b1;
               end else begin
                  state_d   = ST_ERR;
                  m_ready_d = 1'b1;
                  m_rdata_d = ERR_RDATA;
               end
            end
         end

         ST_REQ: begin
            // Ready in the final counted cycle takes precedence over the timeout.
            if (sel_ready) begin
               state_d   = ST_RESP;
               m_ready_d = 1'b1;
               m_rdata_d = sel_rdata;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = ST_RESP;
               m_ready_d  = 1'b1;
               m_rdata_d  = ERR_RDATA;
               err_d      = 1'b1;
               err_addr_d = s_addr_q;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               s_valid_d = s_valid_q;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         ST_ERR: begin
            // The master still holds its address while it sees m_ready_o.
            state_d    = ST_IDLE;
            err_d      = 1'b1;
            err_addr_d = m_addr_i;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sel_q      <= '0;
         s_valid_q  <= '0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
         s_wstrb_q  <= '0;
         m_ready_q  <= 1'b0;
         m_rdata_q  <= '0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         s_valid_q  <= s_valid_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
         s_wstrb_q  <= s_wstrb_d;
         m_ready_q  <= m_ready_d;
         m_rdata_q  <= m_rdata_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign m_ready_o  = m_ready_q;
   assign m_rdata_o  = m_rdata_q;
   assign s_valid_o  = s_valid_q;
   assign s_addr_o   = s_addr_q;
   assign s_wdata_o  = s_wdata_q;
   assign s_wstrb_o  = s_wstrb_q;
   assign err_o      = err_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_nmi_slave_demux.sv
// Self-checking bench for nmi_slave_demux: a driver plays master and slaves,
// expected responses are queued per transaction and matched when m_ready_o pulses.
module tb_nmi_slave_demux;

   localparam int NS = 4;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           m_valid_i = 1'b0;
   logic [31:0]    m_addr_i = '0;
   logic [31:0]    m_wdata_i = '0;
   logic [3:0]     m_wstrb_i = '0;
   logic           m_ready_o;
   logic [31:0]    m_rdata_o;
   logic [NS-1:0]  s_valid_o;
   logic [31:0]    s_addr_o;
   logic [31:0]    s_wdata_o;
   logic [3:0]     s_wstrb_o;
   logic [NS-1:0]  s_ready_i = '0;
   logic [NS*32-1:0] s_rdata_i = '0;
   logic           err_clr_i = 1'b0;
   logic           err_o;
   logic [31:0]    err_addr_o;

   nmi_slave_demux #(.TIMEOUT_CYC(4)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .m_valid_i  (m_valid_i),
      .m_addr_i   (m_addr_i),
      .m_wdata_i  (m_wdata_i),
      .m_wstrb_i  (m_wstrb_i),
      .m_ready_o  (m_ready_o),
      .m_rdata_o  (m_rdata_o),
      .s_valid_o  (s_valid_o),
      .s_addr_o   (s_addr_o),
      .s_wdata_o  (s_wdata_o),
      .s_wstrb_o  (s_wstrb_o),
      .s_ready_i  (s_ready_i),
      .s_rdata_i  (s_rdata_i),
      .err_clr_i  (err_clr_i),
      .err_o      (err_o),
      .err_addr_o (err_addr_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   typedef struct {
      int          cyc;
      logic [31:0] rdata;
   } resp_t;

   resp_t sb_q[$];

   // Response monitor: every m_ready_o pulse must match the oldest queued expectation.
   always @(negedge clk_i) begin
      if (m_ready_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_m_ready", 32'(m_ready_o), 32'd0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
            check("resp_rdata", m_rdata_o, e.rdata);
         end
      end
   end

   function automatic logic [NS*32-1:0] junk_rdata();
      logic [NS*32-1:0] v;
      for (int i = 0; i < NS; i++) v[i*32 +: 32] = 32'h0BAD_0000 + 32'(i);
      return v;
   endfunction

   // One master transaction. rdy_cyc < 0 means the slave never answers;
   // exp_sv == 0 means a decode miss is expected.
   task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int rdy_slv, input int rdy_cyc,
                          input logic [31:0] rdy_data, input logic [NS-1:0] exp_sv,
                          input int exp_resp, input logic [31:0] exp_rdata,
                          input int clr_cyc);
      int    t0;
      int    last;
      resp_t e;
      @(negedge clk_i);
      t0        = cyc;
      m_valid_i = 1'b1;
      m_addr_i  = addr;
      m_wdata_i = wdata;
      m_wstrb_i = wstrb;
      e.cyc     = t0 + exp_resp;
      e.rdata   = exp_rdata;
      sb_q.push_back(e);
      last = ((rdy_cyc > exp_resp) ? rdy_cyc : exp_resp) + 1;
      for (int rel = 0; rel <= last; rel++) begin
         if (rel > 0) @(negedge clk_i);
         if (rel >= 1) begin
            check($sformatf("s_valid_c%0d", rel), 32'(s_valid_o),
                  (rel < exp_resp) ? 32'(exp_sv) : 32'd0);
            if (exp_sv != '0 && rel < exp_resp) begin
               check("s_addr", s_addr_o, addr);
               check("s_wdata", s_wdata_o, wdata);
               check("s_wstrb", 32'(s_wstrb_o), 32'(wstrb));
            end
         end
         // Address wobble during REQ must not reach the slave side.
         if (exp_sv != '0 && rel >= 1 && rel < exp_resp) m_addr_i = ~addr;
         if (rel == exp_resp) m_valid_i = 1'b0;
         s_rdata_i = junk_rdata();
         s_ready_i = '0;
         if (rel == rdy_cyc) begin
            s_ready_i[rdy_slv]           = 1'b1;
            s_rdata_i[rdy_slv*32 +: 32]  = rdy_data;
         end
         err_clr_i = (rel == clr_cyc);
      end
      s_ready_i = '0;
      err_clr_i = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk_i);
      err_clr_i = 1'b1;
      @(negedge clk_i);
      err_clr_i = 1'b0;
      check("err_after_clr", 32'(err_o), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk_i);
      check("rst_s_valid", 32'(s_valid_o), 32'd0);
      check("rst_m_ready", 32'(m_ready_o), 32'd0);
      check("rst_m_rdata", m_rdata_o, 32'd0);
      check("rst_s_addr", s_addr_o, 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_err_addr", err_addr_o, 32'd0);
      rst_i = 1'b0;

      // Read from slave 1, ready in cycle 3.
      run_txn(32'h1000_0010, 32'h0, 4'b0000, 1, 3, 32'h1234_5678, 4'b0010, 4, 32'h1234_5678, -1);
      check("t1_err", 32'(err_o), 32'd0);

      // Zero-wait write to slave 3.
      run_txn(32'h4000_0004, 32'hA5A5_A5A5, 4'b0011, 3, 1, 32'h0000_1111, 4'b1000, 2, 32'h0000_1111, -1);
      check("t2_err", 32'(err_o), 32'd0);

      // Decode miss.
      run_txn(32'h8000_0000, 32'h0, 4'b0000, 0, -1, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, -1);
      check("miss_err", 32'(err_o), 32'd1);
      check("miss_err_addr", err_addr_o, 32'h8000_0000);
      clear_err();

      // New miss with a clear in the same cycle: set wins.
      run_txn(32'h9000_0000, 32'h0, 4'b1111, 0, -1, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 1);
      check("miss2_err", 32'(err_o), 32'd1);
      check("miss2_err_addr", err_addr_o, 32'h9000_0000);
      clear_err();

      // Timeout on slave 0, late ready in cycle 6 is ignored.
      run_txn(32'h0000_0100, 32'h0, 4'b0000, 0, 6, 32'h7777_7777, 4'b0001, 5, 32'hDEAD_BEEF, -1);
      check("to_err", 32'(err_o), 32'd1);
      check("to_err_addr", err_addr_o, 32'h0000_0100);
      clear_err();

      // Ready in the final timeout cycle wins.
      run_txn(32'h0000_0200, 32'h0, 4'b0000, 0, 4, 32'h0000_00FF, 4'b0001, 5, 32'h0000_00FF, -1);
      check("edge_err", 32'(err_o), 32'd0);

      // Reset in cycle 2 of a pending access to slave 1.
      @(negedge clk_i);
      m_valid_i = 1'b1;
      m_addr_i  = 32'h1000_0020;
      m_wstrb_i = 4'b0000;
      repeat (2) @(negedge clk_i);
      check("pre_rst_s_valid", 32'(s_valid_o), 32'b0010);
      rst_i     = 1'b1;
      m_valid_i = 1'b0;
      @(negedge clk_i);
      check("mid_rst_s_valid", 32'(s_valid_o), 32'd0);
      check("mid_rst_m_ready", 32'(m_ready_o), 32'd0);
      check("mid_rst_s_addr", s_addr_o, 32'd0);
      check("mid_rst_m_rdata", m_rdata_o, 32'd0);
      rst_i = 1'b0;

      // Normal read after reset: slave 2, ready in cycle 2.
      run_txn(32'h3000_0008, 32'h0, 4'b0000, 2, 2, 32'hCAFE_F00D, 4'b0100, 3, 32'hCAFE_F00D, -1);
      check("post_rst_err", 32'(err_o), 32'd0);

      repeat (3) @(negedge clk_i);
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
